// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out transmitter. A WIDTH-bit word is accepted through a
//   valid/ready handshake and shifted out one bit per shift_en tick. A
//   one-cycle done pulse follows the consumption of the last bit of a frame.
//
// Ports
//   clk         in   1      system clock, rising edge
//   sync_rst    in   1      synchronous reset, active high
//   load_valid  in   1      source offers data_in
//   load_ready  out  1      block can accept a word (IDLE only)
//   data_in     in   WIDTH  parallel word, sampled only on accept
//   shift_en    in   1      bit-rate tick; consumes the current bit
//   ser_out     out  1      serial data, registered
//   ser_valid   out  1      ser_out carries a frame bit
//   busy        out  1      frame in progress; this is the FSM state
//                           (high exactly when state == SHIFT)
//   done        out  1      one-cycle pulse after the last bit is consumed
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready does not depend on load_valid, and a
// source may hold load_valid high across any number of cycles; nothing is
// captured while load_ready is low.
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;
    logic               accept;

    // The bit presented on the line is always the "front" of the shift
    // register, so the same selection serves both load and shift.
    function automatic logic front_bit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    assign load_ready = (state_q == IDLE);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ser_d = IDLE_LEVEL;
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = data_in;
                    cnt_d   = '0;
                    ser_d   = front_bit(data_in);
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == LAST_CNT) begin
                        // Last bit consumed: the line returns to idle in the
                        // same cycle that done pulses, so a new word can be
                        // accepted right away.
                        state_d = IDLE;
                        cnt_d   = '0;
                        ser_d   = IDLE_LEVEL;
                        done_d  = 1'b1;
                    end else begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q + 1'b1;
                        ser_d = front_bit(shreg_d);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ser_d   = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign ser_out   = ser_q;
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer. Two instances share the clock: one
//   MSB-first (default) and one LSB-first. Inputs change 1 time unit after
//   the rising edge; outputs are compared at that same point.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first instance
    logic       sync_rst, load_valid, load_ready, shift_en;
    logic [7:0] data_in;
    logic       ser_out, ser_valid, busy, done;

    // LSB-first instance
    logic       l_sync_rst, l_load_valid, l_load_ready, l_shift_en;
    logic [7:0] l_data_in;
    logic       l_ser_out, l_ser_valid, l_busy, l_done;

    int checks   = 0;
    int failures = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .shift_en   (shift_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk        (clk),
        .sync_rst   (l_sync_rst),
        .load_valid (l_load_valid),
        .load_ready (l_load_ready),
        .data_in    (l_data_in),
        .shift_en   (l_shift_en),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .busy       (l_busy),
        .done       (l_done)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle load into the MSB-first instance; returns just after the
    // accepting edge, which is the first bit cycle.
    task automatic load_word(input logic [7:0] w);
        data_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sync_rst = 1'b1; load_valid = 1'b1; data_in = 8'hFF; shift_en = 1'b1;
        l_sync_rst = 1'b1; l_load_valid = 1'b1; l_data_in = 8'hFF; l_shift_en = 1'b1;
        step();
        step();
        checks++; if (ser_out !== 1'b1) begin failures++; $display("FAIL reset_ser_out got=%b exp=1", ser_out); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL reset_ser_valid got=%b exp=0", ser_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
        checks++; if ({l_ser_out, l_ser_valid, l_busy, l_done, l_load_ready} !== 5'b10001) begin
            failures++; $display("FAIL reset_lsb_outputs got=%b exp=10001", {l_ser_out, l_ser_valid, l_busy, l_done, l_load_ready});
        end
        sync_rst = 1'b0; load_valid = 1'b0;
        l_sync_rst = 1'b0; l_load_valid = 1'b0;
        step();
        // The word offered during reset must not have been captured.
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL reset_no_capture got=%b exp=0", ser_valid); end
    endtask

    task automatic test_msb_basic();
        logic [7:0] w;
        logic       e;
        logic       exp_q[$];
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        shift_en = 1'b1;
        load_word(w);
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL msb_load_ready_busy got=%b exp=0", load_ready); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (ser_out !== e) begin failures++; $display("FAIL msb_bit%0d got=%b exp=%b", i, ser_out, e); end
            checks++; if (ser_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL msb_valid%0d got=%b%b exp=11", i, ser_valid, busy); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL msb_early_done%0d got=%b exp=0", i, done); end
            step();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL msb_done got=%b exp=1", done); end
        checks++; if ({ser_valid, ser_out, load_ready} !== 3'b011) begin
            failures++; $display("FAIL msb_done_idle got=%b exp=011", {ser_valid, ser_out, load_ready});
        end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL msb_done_width got=%b exp=0", done); end
    endtask

    task automatic test_lsb_slow();
        logic [7:0] w;
        logic       e;
        logic       exp_q[$];
        w = 8'h81;
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        l_shift_en   = 1'b0;
        l_data_in    = w;
        l_load_valid = 1'b1;
        step();
        l_load_valid = 1'b0;
        l_data_in    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                l_shift_en = (c == 2);
                checks++; if (l_ser_out !== e) begin failures++; $display("FAIL lsb_bit%0d_c%0d got=%b exp=%b", i, c, l_ser_out, e); end
                checks++; if (l_ser_valid !== 1'b1 || l_done !== 1'b0) begin
                    failures++; $display("FAIL lsb_valid%0d_c%0d got=%b%b exp=10", i, c, l_ser_valid, l_done);
                end
                step();
            end
        end
        l_shift_en = 1'b0;
        checks++; if (l_done !== 1'b1 || l_ser_valid !== 1'b0) begin
            failures++; $display("FAIL lsb_done got=%b%b exp=10", l_done, l_ser_valid);
        end
        step();
        checks++; if (l_done !== 1'b0) begin failures++; $display("FAIL lsb_done_width got=%b exp=0", l_done); end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] w;
        logic       e;
        logic       exp_q[$];
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        shift_en = 1'b1;
        load_word(w);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin load_valid = 1'b1; data_in = 8'hFF; end
            if (i == 6) begin load_valid = 1'b0; data_in = 8'h00; end
            if (i >= 2 && i < 6) begin
                checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL busy_load_ready%0d got=%b exp=0", i, load_ready); end
            end
            e = exp_q.pop_front();
            checks++; if (ser_out !== e) begin failures++; $display("FAIL busy_bit%0d got=%b exp=%b", i, ser_out, e); end
            step();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_done got=%b exp=1", done); end
        step();
        checks++; if (ser_valid !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL busy_no_second_frame got=%b%b exp=00", ser_valid, done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        logic       e;
        logic       exp_q[$];
        w = 8'hA5;
        shift_en = 1'b1;
        load_word(w);
        for (int i = 0; i < 3; i++) begin
            checks++; if (ser_out !== w[7-i]) begin failures++; $display("FAIL abort_bit%0d got=%b exp=%b", i, ser_out, w[7-i]); end
            step();
        end
        sync_rst = 1'b1; load_valid = 1'b1; data_in = 8'h3C;
        step();
        sync_rst = 1'b0; load_valid = 1'b0; data_in = 8'h00;
        checks++; if ({ser_valid, busy, done, ser_out, load_ready} !== 5'b00011) begin
            failures++; $display("FAIL abort_idle got=%b exp=00011", {ser_valid, busy, done, ser_out, load_ready});
        end
        step();
        checks++; if (done !== 1'b0 || ser_valid !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got=%b%b exp=00", done, ser_valid);
        end
        w = 8'h3C;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        load_word(w);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (ser_out !== e) begin failures++; $display("FAIL after_abort_bit%0d got=%b exp=%b", i, ser_out, e); end
            step();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL after_abort_done got=%b exp=1", done); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        logic       e;
        logic       exp_q[$];
        w0 = 8'h0F;
        w1 = 8'hF0;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w0[i]);
        shift_en   = 1'b1;
        data_in    = w0;
        load_valid = 1'b1;
        step();
        data_in = w1;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (ser_out !== e || ser_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_f0_bit%0d got=%b%b exp=%b1", i, ser_out, ser_valid, e);
            end
            step();
        end
        checks++; if ({done, ser_valid, ser_out, load_ready} !== 4'b1011) begin
            failures++; $display("FAIL b2b_gap got=%b exp=1011", {done, ser_valid, ser_out, load_ready});
        end
        step();
        load_valid = 1'b0;
        data_in    = 8'h00;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (ser_out !== e || ser_valid !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL b2b_f1_bit%0d got=%b%b%b exp=%b10", i, ser_out, ser_valid, done, e);
            end
            step();
        end
        checks++; if (done !== 1'b1 || ser_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_f1_done got=%b%b exp=10", done, ser_valid);
        end
        step();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        sync_rst = 1'b0; load_valid = 1'b0; data_in = 8'h00; shift_en = 1'b0;
        l_sync_rst = 1'b0; l_load_valid = 1'b0; l_data_in = 8'h00; l_shift_en = 1'b0;
        test_reset();
        test_msb_basic();
        test_lsb_slow();
        test_busy_ignore();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
